// File: rtl/sink_run_controller.sv
// rtl/sink_run_controller.sv - run-length sequencer forwarding network beats to the sink through a one-entry register
module sink_run_controller #(
    parameter int NUM_OUT   = 8,
    parameter int RUN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [RUN_WIDTH-1:0] cmd_runs,
    input  logic                 net_valid,
    output logic                 net_ready,
    input  logic [NUM_OUT-1:0]   net_out,
    input  logic                 snk_ready,
    output logic                 snk_valid,
    output logic [NUM_OUT-1:0]   snk,
    output logic                 snk_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [RUN_WIDTH-1:0] remaining;
    logic [NUM_OUT-1:0]   net_rev;
    logic                 net_accept;
    logic                 snk_take;
    logic                 last_beat;

    always_comb begin
        net_rev = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            net_rev[NUM_OUT-1-i] = net_out[i];
        end
    end

    assign net_accept = net_valid && net_ready;
    assign snk_take   = snk_valid && snk_ready;
    assign last_beat  = (remaining == RUN_WIDTH'(1));

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        net_ready  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid && (cmd_runs != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // The register may refill in the same cycle it drains.
                net_ready = !snk_valid || snk_ready;
                if (net_valid && net_ready && last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (snk_valid && snk_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            remaining <= '0;
            snk_valid <= 1'b0;
            snk       <= '0;
            snk_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // A zero-length command completes immediately without producing a beat.
            done <= ((state == IDLE) && cmd_valid && (cmd_runs == '0)) ||
                    ((state == DRAIN) && snk_take);
            if ((state == IDLE) && cmd_valid) begin
                remaining <= cmd_runs;
            end else if (net_accept) begin
                remaining <= remaining - RUN_WIDTH'(1);
            end
            if (net_accept) begin
                snk       <= net_rev;
                snk_valid <= 1'b1;
                snk_last  <= last_beat;
            end else if (snk_take) begin
                snk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sink_run_controller.sv
// tb/tb_sink_run_controller.sv - self-checking bench for sink_run_controller
module tb_sink_run_controller;

    logic        clk = 1'b0;
    logic        arstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_runs;
    logic        net_valid;
    logic        net_ready;
    logic [7:0]  net_out;
    logic        snk_ready;
    logic        snk_valid;
    logic [7:0]  snk;
    logic        snk_last;
    logic        busy;
    logic        done;

    sink_run_controller #(.NUM_OUT(8), .RUN_WIDTH(16)) dut (
        .clk(clk), .arstn(arstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
        .net_valid(net_valid), .net_ready(net_ready), .net_out(net_out),
        .snk_ready(snk_ready), .snk_valid(snk_valid), .snk(snk), .snk_last(snk_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: run bookkeeping in terms of beats still owed
    bit       m_known = 0;
    bit       m_busy, m_drain, m_ov, m_ol, m_done;
    int       m_left;
    bit [7:0] m_od;

    int n_beats, n_lasts, n_dones;
    bit acc_flag, cmd_acc_flag;

    typedef struct {
        logic [7:0] net;
        logic [7:0] exp_snk;
        logic       exp_last;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] mirror(input bit [7:0] v);
        bit [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (((v >> i) & 8'h01) != 0) r = r | (8'h80 >> i);
        end
        return r;
    endfunction

    task automatic cycle();
        bit e_nr, acc, take, d;
        #1;
        e_nr = m_busy && !m_drain && (!m_ov || snk_ready);
        if (m_known && arstn) begin
            check("cmd_ready", cmd_ready, m_busy ? 0 : 1);
            check("busy", busy, m_busy);
            check("net_ready", net_ready, e_nr);
        end
        acc_flag     = net_valid && net_ready;
        cmd_acc_flag = cmd_valid && cmd_ready;
        if (snk_valid && snk_ready) begin
            n_beats++;
            if (snk_last) n_lasts++;
        end
        @(posedge clk);
        if (!arstn) begin
            m_known = 1; m_busy = 0; m_drain = 0; m_ov = 0; m_ol = 0;
            m_done = 0; m_left = 0; m_od = 0;
        end else if (m_known) begin
            d    = 0;
            acc  = net_valid && e_nr;
            take = m_ov && snk_ready;
            if (!m_busy) begin
                if (cmd_valid) begin
                    if (cmd_runs != 0) begin
                        m_busy = 1;
                        m_left = int'(cmd_runs);
                    end else begin
                        d = 1;
                    end
                end
            end else if (!m_drain) begin
                if (acc) begin
                    m_od   = mirror(net_out);
                    m_ol   = (m_left == 1);
                    m_left = m_left - 1;
                    m_ov   = 1;
                    if (m_left == 0) m_drain = 1;
                end else if (take) begin
                    m_ov = 0;
                end
            end else if (take) begin
                m_ov = 0; d = 1; m_busy = 0; m_drain = 0;
            end
            m_done = d;
        end
        #1;
        if (done === 1'b1) n_dones++;
        if (m_known) begin
            check("snk_valid", snk_valid, m_ov);
            check("done", done, m_done);
            if (m_ov) begin
                check("snk", snk, m_od);
                check("snk_last", snk_last, m_ol);
            end
        end
    endtask

    task automatic clear_counts();
        n_beats = 0; n_lasts = 0; n_dones = 0;
    endtask

    task automatic run_until_done(input int want, input int budget, input string name);
        int k = 0;
        while (n_dones < want && k < budget) begin
            cycle();
            k++;
        end
        check(name, n_dones, want);
    endtask

    initial begin
        vecs[0] = '{net: 8'h01, exp_snk: 8'h80, exp_last: 1'b0};
        vecs[1] = '{net: 8'h02, exp_snk: 8'h40, exp_last: 1'b0};
        vecs[2] = '{net: 8'h80, exp_snk: 8'h01, exp_last: 1'b1};

        // Reset with active traffic on the inputs
        arstn = 0; cmd_valid = 1; cmd_runs = 16'd3; net_valid = 1; net_out = 8'hA5; snk_ready = 0;
        repeat (3) cycle();
        check("rst_snk_valid", snk_valid, 0);
        check("rst_snk", snk, 0);
        check("rst_snk_last", snk_last, 0);
        check("rst_done", done, 0);
        arstn = 1; cmd_valid = 0; net_valid = 0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_net_ready", net_ready, 0);
        cycle();
        cycle();
        check("idle_hold_snk", snk, 0);

        // Basic run from the vector table
        clear_counts();
        cmd_valid = 1; cmd_runs = 16'd3; snk_ready = 1;
        cycle();
        cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            net_valid = 1; net_out = vecs[i].net;
            cycle();
            check("basic_snk", snk, vecs[i].exp_snk);
            check("basic_last", snk_last, vecs[i].exp_last);
            check("basic_valid", snk_valid, 1);
        end
        net_valid = 0;
        run_until_done(1, 10, "basic_done_count");
        cycle(); cycle();
        check("basic_beats", n_beats, 3);
        check("basic_dones", n_dones, 1);
        check("basic_idle", busy, 0);

        // Backpressure: snk_ready pattern 1,0,0,1 repeating; upstream holds until accepted
        clear_counts();
        cmd_valid = 1; cmd_runs = 16'd4;
        cycle();
        cmd_valid = 0; net_valid = 1; net_out = 8'h11;
        for (int k = 0; k < 40 && n_dones < 1; k++) begin
            snk_ready = ((k % 4) == 0) || ((k % 4) == 3);
            cycle();
            if (acc_flag) net_out = net_out + 8'h11;
        end
        net_valid = 0; snk_ready = 1;
        cycle();
        check("bp_beats", n_beats, 4);
        check("bp_lasts", n_lasts, 1);
        check("bp_dones", n_dones, 1);

        // Zero-length command
        clear_counts();
        cmd_valid = 1; cmd_runs = 16'd0;
        cycle();
        cmd_valid = 0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", snk_valid, 0);
        cycle();
        check("zero_done_once", done, 0);

        // Reset in the middle of a run
        clear_counts();
        cmd_valid = 1; cmd_runs = 16'd5; snk_ready = 1;
        cycle();
        cmd_valid = 0; net_valid = 1; net_out = 8'h0F;
        cycle(); cycle();
        net_valid = 0; arstn = 0;
        cycle();
        check("midrst_valid", snk_valid, 0);
        check("midrst_done", done, 0);
        arstn = 1;
        #1;
        check("midrst_busy", busy, 0);
        clear_counts();
        cmd_valid = 1; cmd_runs = 16'd2;
        cycle();
        cmd_valid = 0; net_valid = 1; net_out = 8'h3C;
        run_until_done(1, 20, "midrst_done_count");
        net_valid = 0;
        check("midrst_beats", n_beats, 2);

        // Back-to-back commands with cmd_valid held
        clear_counts();
        begin
            int n_cmds = 0;
            cmd_valid = 1; cmd_runs = 16'd2; net_valid = 1; net_out = 8'h81; snk_ready = 1;
            for (int k = 0; k < 30 && n_dones < 2; k++) begin
                cycle();
                if (acc_flag) net_out = 8'($urandom);
                if (cmd_acc_flag) begin
                    n_cmds++;
                    if (n_cmds == 1) cmd_runs = 16'd1;
                    else cmd_valid = 0;
                end
            end
            net_valid = 0; cmd_valid = 0;
            cycle();
            check("b2b_cmds", n_cmds, 2);
        end
        check("b2b_beats", n_beats, 3);
        check("b2b_lasts", n_lasts, 2);
        check("b2b_dones", n_dones, 2);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            arstn     = ($urandom_range(0, 299) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_runs  = 16'($urandom_range(0, 5));
            net_valid = ($urandom_range(0, 3) != 0);
            net_out   = 8'($urandom);
            snk_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
